// File: rtl/blake_pkg.sv
// blake_pkg: shared state encoding and sizing constants for the BLAKE-512 round sequencer
package blake_pkg;
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_FINAL, S_HOLD} state_t;
  localparam int NUM_ROUNDS_512 = 16;
  localparam int SIGMA_ROWS = 10;
  localparam int STEPS_512 = 4;
  localparam int ROUND_W = $clog2(NUM_ROUNDS_512);
  localparam int STEP_W = $clog2(STEPS_512);
  localparam int SIGMA_W = $clog2(SIGMA_ROWS);
endpackage

// File: rtl/blake_round_cnt.sv
// blake_round_cnt: step/round/sigma-row counter chain with clear, advance and last-step flag
module blake_round_cnt #(
  parameter int NUM_ROUNDS = 16,
  parameter int STEPS = 4,
  parameter int SIGMA_N = 10,
  localparam int RW = $clog2(NUM_ROUNDS),
  localparam int SW = $clog2(STEPS),
  localparam int GW = $clog2(SIGMA_N)
)(
  input  logic          clk,
  input  logic          rstb,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] round_idx,
  output logic [SW-1:0] step_idx,
  output logic [GW-1:0] sigma_row,
  output logic          last
);
  logic step_wrap;
  assign step_wrap = step_idx == SW'(STEPS - 1);
  assign last = step_wrap && round_idx == RW'(NUM_ROUNDS - 1);
  // Step rolls into round; sigma row tracks the round with its own wrap instead of a modulo.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      step_idx  <= '0;
      round_idx <= '0;
      sigma_row <= '0;
    end else if (clear) begin
      step_idx  <= '0;
      round_idx <= '0;
      sigma_row <= '0;
    end else if (advance) begin
      step_idx <= step_wrap ? '0 : step_idx + 1'b1;
      if (step_wrap) begin
        round_idx <= round_idx + 1'b1;
        sigma_row <= sigma_row == GW'(SIGMA_N - 1) ? '0 : sigma_row + 1'b1;
      end
    end
  end
endmodule

// File: rtl/blake_round_ctrl.sv
// blake_round_ctrl: round sequencer FSM driving the BLAKE-512 state register and G-stage indices
module blake_round_ctrl
  import blake_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_512,
  parameter int STEPS_PER_ROUND = STEPS_512,
  parameter int SIGMA_ROWS = blake_pkg::SIGMA_ROWS
)(
  input  logic               clk,
  input  logic               rstb,
  input  logic               start_valid,
  output logic               start_ready,
  output logic               init_round,
  output logic               round_ing,
  output logic               count_done,
  output logic [ROUND_W-1:0] round_idx,
  output logic [STEP_W-1:0]  step_idx,
  output logic [SIGMA_W-1:0] sigma_row,
  output logic               diag,
  output logic               out_valid,
  input  logic               out_ready
);
  state_t state_q, state_d;
  logic last;
  logic clear;
  logic advance;
  // Indices restart on acceptance of a request and on release of the result; they freeze after the last step.
  assign clear = (start_valid && start_ready) || (out_valid && out_ready);
  assign advance = round_ing && !last;
  assign diag = step_idx >= STEP_W'(STEPS_PER_ROUND / 2);
  blake_round_cnt #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .STEPS(STEPS_PER_ROUND),
    .SIGMA_N(SIGMA_ROWS)
  ) u_cnt (
    .clk(clk),
    .rstb(rstb),
    .clear(clear),
    .advance(advance),
    .round_idx(round_idx),
    .step_idx(step_idx),
    .sigma_row(sigma_row),
    .last(last)
  );
  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // Next state and strobes decoded purely from the registered state.
  always_comb begin
    state_d = state_q;
    start_ready = 1'b0;
    init_round = 1'b0;
    round_ing = 1'b0;
    count_done = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_d = S_INIT;
      end
      S_INIT: begin
        init_round = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        round_ing = 1'b1;
        if (last) state_d = S_FINAL;
      end
      S_FINAL: begin
        count_done = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State-register control strobes never overlap.
  assert property (@(posedge clk) disable iff (!rstb) $onehot0({init_round, round_ing, count_done}));
endmodule
